// File: rtl/counter_run_sequencer_pkg.sv
// Shared types and defaults for the counter run sequencer and its watchdog.
package counter_run_sequencer_pkg;

   localparam int          CNT_W          = 8;
   localparam int          DEF_TO_W       = 24;
   localparam logic [23:0] DEF_TO_CYCLES  = 24'd10_000_000;
   localparam int          DEF_GAP_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_run_sequencer_run_watchdog.sv
// Per-run watchdog: counts cycles while enabled and flags the last allowed cycle.
module run_watchdog
   import counter_run_sequencer_pkg::*;
#(
   parameter int              TO_W      = DEF_TO_W,
   parameter logic [TO_W-1:0] TO_CYCLES = TO_W'(DEF_TO_CYCLES)
) (
   input  logic qzt_clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] count;

   // Holds at the terminal value so a missed clear can never wrap into a fresh window.
   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TO_CYCLES - 1'b1);

endmodule

// File: rtl/counter_run_sequencer.sv
// Sequences an external one-run edge counter: run, wait for carry, gap, repeat,
// with a per-run watchdog and progress/completion/timeout reporting.
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | ctr_run high, waiting for carry or watchdog expiry
// GAP   | ctr_run low so the counter clears before the next run
// DONE  | one-cycle end-of-sequence pulse, then back to IDLE
module counter_run_sequencer
   import counter_run_sequencer_pkg::*;
#(
   parameter int              TO_W       = DEF_TO_W,
   parameter logic [TO_W-1:0] TO_CYCLES  = TO_W'(DEF_TO_CYCLES),
   parameter int              GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic             qzt_clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] limit_cfg,
   input  logic [CNT_W-1:0] runs_cfg,
   input  logic             ctr_carry,
   output logic             ctr_run,
   output logic [CNT_W-1:0] ctr_limit,
   output logic             busy,
   output logic             run_pulse,
   output logic [CNT_W-1:0] runs_done,
   output logic             done,
   output logic             timeout,
   output logic             cfg_err
);

   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] runs_cfg_q;
   logic [CNT_W-1:0] runs_inc;
   logic [GAP_W-1:0] gap_cnt;
   logic             expired;
   logic             start_ok;
   logic             last_run;

   assign start_ok = (state == ST_IDLE) && start && !abort;
   assign runs_inc = runs_done + 1'b1;
   // Zero runs_cfg means continuous, so the wrap of runs_inc to 0 must not end it.
   assign last_run = (runs_cfg_q != '0) && (runs_inc == runs_cfg_q);

   run_watchdog #(
      .TO_W      (TO_W),
      .TO_CYCLES (TO_CYCLES)
   ) u_watchdog (
      .qzt_clk (qzt_clk),
      .reset   (reset),
      .clr     (state != ST_RUN),
      .en      (state == ST_RUN),
      .expired (expired)
   );

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start_ok && (limit_cfg != '0)) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (abort)          state_nx = ST_DONE;
            else if (ctr_carry) state_nx = last_run ? ST_DONE : ST_GAP;
            else if (expired)   state_nx = ST_DONE;
         end
         ST_GAP: begin
            if (abort)                state_nx = ST_DONE;
            else if (gap_cnt == '0)   state_nx = ST_RUN;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      ctr_run = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         ST_RUN: begin
            ctr_run = 1'b1;
            busy    = 1'b1;
         end
         ST_GAP:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         ctr_limit  <= '0;
         runs_cfg_q <= '0;
         runs_done  <= '0;
         timeout    <= 1'b0;
         run_pulse  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         run_pulse <= 1'b0;
         cfg_err   <= 1'b0;
         if (start_ok) begin
            if (limit_cfg != '0) begin
               ctr_limit  <= limit_cfg;
               runs_cfg_q <= runs_cfg;
               runs_done  <= '0;
               timeout    <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
         end
         // Abort beats carry, and carry beats expiry.
         if ((state == ST_RUN) && !abort) begin
            if (ctr_carry) begin
               runs_done <= runs_inc;
               run_pulse <= 1'b1;
            end else if (expired) begin
               timeout <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= '0;
      end else if (state == ST_RUN) begin
         gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Scoreboard bench: expected events are queued at stimulus time and popped by a
// monitor when the sequencer reports run_pulse, done or cfg_err.
module tb_counter_run_sequencer;

   localparam int TO  = 100;
   localparam int GAP = 2;
   localparam int K_PULSE = 0;
   localparam int K_DONE  = 1;
   localparam int K_CFG   = 2;

   logic       qzt_clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] limit_cfg;
   logic [7:0] runs_cfg;
   logic       ctr_carry;
   logic       ctr_run;
   logic [7:0] ctr_limit;
   logic       busy;
   logic       run_pulse;
   logic [7:0] runs_done;
   logic       done;
   logic       timeout;
   logic       cfg_err;

   typedef struct {
      int kind;
      int rd;
      int to;
   } evt_t;

   evt_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   hi_len = 0;
   int   last_hi = 0;
   int   gap_len = 0;
   bit   cnt_en = 1'b1;
   bit   inject = 1'b0;
   int   cnt = 0;
   int   run_cyc = 0;

   counter_run_sequencer #(
      .TO_W       (24),
      .TO_CYCLES  (24'd100),
      .GAP_CYCLES (GAP)
   ) dut (
      .qzt_clk   (qzt_clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .limit_cfg (limit_cfg),
      .runs_cfg  (runs_cfg),
      .ctr_carry (ctr_carry),
      .ctr_run   (ctr_run),
      .ctr_limit (ctr_limit),
      .busy      (busy),
      .run_pulse (run_pulse),
      .runs_done (runs_done),
      .done      (done),
      .timeout   (timeout),
      .cfg_err   (cfg_err)
   );

   initial begin
      qzt_clk = 1'b0;
      forever #5 qzt_clk = ~qzt_clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input int rd, input int to);
      evt_t e;
      e.kind = k;
      e.rd   = rd;
      e.to   = to;
      exp_q.push_back(e);
   endtask

   task automatic expect_seq(input int runs);
      for (int i = 1; i <= runs; i++) push(K_PULSE, i % 256, 0);
      push(K_DONE, runs % 256, 0);
   endtask

   task automatic check_evt(input int kind);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d runs_done=%0d timeout=%0d, expected none at %0t",
                  kind, runs_done, timeout, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind != K_CFG && int'(runs_done) != e.rd) ||
             (kind == K_DONE && int'(timeout) != e.to)) begin
            errors++;
            $display("FAIL event: got kind=%0d runs_done=%0d timeout=%0d, expected kind=%0d runs_done=%0d timeout=%0d at %0t",
                     kind, runs_done, timeout, e.kind, e.rd, e.to, $time);
         end
      end
   endtask

   // Monitor: event scoreboard plus run/gap length measurement.
   always @(negedge qzt_clk) begin
      if (run_pulse) check_evt(K_PULSE);
      if (done)      check_evt(K_DONE);
      if (cfg_err)   check_evt(K_CFG);
      if (ctr_run) hi_len++;
      else if (hi_len != 0) begin
         last_hi = hi_len;
         hi_len  = 0;
      end
      if (!busy) gap_len = 0;
      else if (!ctr_run) gap_len++;
      else if (gap_len != 0) begin
         chk("gap_len", gap_len, GAP);
         gap_len = 0;
      end
   end

   // External edge counter: random clk_in edges while run is high, carry at limit.
   initial begin
      ctr_carry = 1'b0;
      forever begin
         @(posedge qzt_clk);
         #1;
         if (!ctr_run) begin
            cnt       = 0;
            run_cyc   = 0;
            ctr_carry = 1'b0;
         end else begin
            run_cyc++;
            if (cnt_en && !ctr_carry && $urandom_range(3) != 0) begin
               cnt++;
               if (cnt >= int'(ctr_limit)) ctr_carry = 1'b1;
            end
            if (inject && run_cyc == TO) ctr_carry = 1'b1;
         end
      end
   end

   task automatic wait_for(input int which, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge qzt_clk);
         case (which)
            0:       seen = run_pulse;
            1:       seen = done;
            default: seen = ctr_run;
         endcase
      end
      chk("wait_event_seen", int'(seen), 1);
   endtask

   task automatic do_start(input int lim, input int runs);
      @(negedge qzt_clk);
      limit_cfg = 8'(lim);
      runs_cfg  = 8'(runs);
      start     = 1'b1;
      @(negedge qzt_clk);
      start     = 1'b0;
      limit_cfg = 8'($urandom);
      runs_cfg  = 8'($urandom);
      if (lim != 0) begin
         chk("start_ctr_run", int'(ctr_run), 1);
         chk("start_busy", int'(busy), 1);
         chk("start_ctr_limit", int'(ctr_limit), lim);
         chk("start_timeout_clr", int'(timeout), 0);
         chk("start_runs_done_clr", int'(runs_done), 0);
      end
   endtask

   initial begin
      int lim;
      int runs;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      limit_cfg = '0;
      runs_cfg  = '0;
      repeat (3) @(negedge qzt_clk);
      chk("rst_ctr_run", int'(ctr_run), 0);
      chk("rst_ctr_limit", int'(ctr_limit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_runs_done", int'(runs_done), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_timeout", int'(timeout), 0);
      reset = 1'b0;
      @(negedge qzt_clk);

      // Three runs of five edges.
      expect_seq(3);
      do_start(5, 3);
      wait_for(1, 400);
      chk("seq3_runs_done", int'(runs_done), 3);
      chk("seq3_timeout", int'(timeout), 0);

      // No carry: watchdog ends the sequence.
      cnt_en = 1'b0;
      push(K_DONE, 0, 1);
      do_start(7, 2);
      wait_for(1, 300);
      @(negedge qzt_clk);
      chk("timeout_run_len", last_hi, TO);
      chk("timeout_sticky", int'(timeout), 1);
      cnt_en = 1'b1;
      expect_seq(1);
      do_start(3, 1);
      wait_for(1, 100);

      // Abort during the second run.
      push(K_PULSE, 1, 0);
      push(K_DONE, 1, 0);
      do_start(8, 4);
      wait_for(0, 200);
      wait_for(2, 20);
      abort = 1'b1;
      @(negedge qzt_clk);
      abort = 1'b0;
      chk("abort_done", int'(done), 1);
      chk("abort_ctr_run", int'(ctr_run), 0);
      chk("abort_runs_done", int'(runs_done), 1);

      // Zero limit is rejected.
      push(K_CFG, 0, 0);
      do_start(0, 2);
      repeat (3) begin
         @(negedge qzt_clk);
         chk("cfg_err_busy", int'(busy), 0);
      end

      // Start together with abort is ignored.
      @(negedge qzt_clk);
      limit_cfg = 8'd5;
      runs_cfg  = 8'd1;
      start     = 1'b1;
      abort     = 1'b1;
      @(negedge qzt_clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      @(negedge qzt_clk);
      chk("start_abort_busy2", int'(busy), 0);

      // Random finite sequences with a stray start while busy.
      for (int s = 0; s < 4; s++) begin
         lim  = int'($urandom_range(4, 30));
         runs = int'($urandom_range(1, 5));
         expect_seq(runs);
         do_start(lim, runs);
         start     = 1'b1;
         limit_cfg = 8'($urandom_range(1, 255));
         runs_cfg  = 8'($urandom_range(1, 255));
         @(negedge qzt_clk);
         start = 1'b0;
         wait_for(1, 400 * runs);
         chk("rand_ctr_limit_held", int'(ctr_limit), lim);
      end

      // Continuous mode through the 255 -> 0 wrap, ended by abort.
      for (int i = 1; i <= 260; i++) push(K_PULSE, i % 256, 0);
      do_start(1, 0);
      for (int i = 0; i < 260; i++) wait_for(0, 100);
      push(K_DONE, 4, 0);
      abort = 1'b1;
      @(negedge qzt_clk);
      abort = 1'b0;
      chk("cont_done", int'(done), 1);

      // Reset in the middle of the second run.
      push(K_PULSE, 1, 0);
      do_start(20, 3);
      wait_for(0, 200);
      wait_for(2, 20);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_ctr_run", int'(ctr_run), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_runs_done", int'(runs_done), 0);
      @(negedge qzt_clk);
      reset = 1'b0;

      // Carry lands on the watchdog's last cycle.
      cnt_en = 1'b0;
      inject = 1'b1;
      push(K_PULSE, 1, 0);
      push(K_DONE, 1, 0);
      do_start(50, 1);
      wait_for(1, 300);
      chk("race_timeout", int'(timeout), 0);
      chk("race_runs_done", int'(runs_done), 1);
      inject = 1'b0;
      cnt_en = 1'b1;

      repeat (5) @(negedge qzt_clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
